// File: rtl/mem_pkg.sv
// Shared types for the MEM stage: memory micro-op codes, FSM states and op classifiers.
package mem_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_t;

    function automatic logic is_load(mem_op_t op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load lane select and sign/zero extension of bus read data.
module mem_load_align
    import mem_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (offset_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = rdata_i;
        case (op_i)
            OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data_o = {24'h000000, byte_sel};
            OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data_o = {16'h0000, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: drives the split addr/data handshake bus and aligns load data for MEM_WB.
// Optional alignment exception checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_in_valid,
    input  logic [3:0]  MEM_in_mem_op,
    input  logic [31:0] MEM_in_alu_result,
    input  logic [31:0] MEM_in_store_data,
    input  logic [4:0]  MEM_in_RF_waddr,
    input  logic        MEM_in_RF_wen,
    input  logic [31:0] MEM_in_PC,
    output logic        dmem_req,
    output logic        dmem_wr,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_addr_ok,
    input  logic        dmem_data_ok,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] MEM_out_RF_wdata,
    output logic [4:0]  MEM_out_RF_waddr,
    output logic        MEM_out_RF_wen,
    output logic [31:0] MEM_out_PC,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        MEM_out_addr_exc,
    output logic [31:0] MEM_out_badvaddr,
`endif
    output logic        MEM_stall
);

    mem_op_t     op;
    mem_state_t  state_q;
    mem_op_t     op_q;
    logic [1:0]  off_q;
    logic        misalign;
    logic        mem_act;
    logic        in_wait;
    logic        done;
    logic [31:0] load_data;

    assign op = mem_op_t'(MEM_in_mem_op);

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        if (MEM_in_valid) begin
            case (op)
                OP_LH, OP_LHU, OP_SH: misalign = MEM_in_alu_result[0];
                OP_LW, OP_SW:         misalign = (MEM_in_alu_result[1:0] != 2'b00);
                default:              misalign = 1'b0;
            endcase
        end
    end

    assign MEM_out_addr_exc = rst_n & misalign;
    assign MEM_out_badvaddr = MEM_in_alu_result;
`else
    assign misalign = 1'b0;
`endif

    assign mem_act = MEM_in_valid & (is_load(op) | is_store(op)) & ~misalign;
    assign in_wait = (state_q == ST_WAIT);
    // data_ok only counts while a transaction is outstanding
    assign done    = in_wait & dmem_data_ok;

    assign dmem_req  = rst_n & mem_act & ~in_wait;
    assign MEM_stall = rst_n & mem_act & ~done;
    assign dmem_wr   = is_store(op);
    assign dmem_addr = {MEM_in_alu_result[31:2], 2'b00};

    always_comb begin
        dmem_wstrb = 4'b0000;
        dmem_wdata = 32'h0000_0000;
        case (op)
            OP_SB: begin
                dmem_wstrb = 4'b0001 << MEM_in_alu_result[1:0];
                dmem_wdata = {4{MEM_in_store_data[7:0]}};
            end
            OP_SH: begin
                dmem_wstrb = MEM_in_alu_result[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{MEM_in_store_data[15:0]}};
            end
            OP_SW: begin
                dmem_wstrb = 4'b1111;
                dmem_wdata = MEM_in_store_data;
            end
            default: begin
                dmem_wstrb = 4'b0000;
                dmem_wdata = 32'h0000_0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NONE;
            off_q   <= 2'b00;
        end else begin
            case (state_q)
                ST_IDLE, ST_REQ: begin
                    if (mem_act && dmem_addr_ok) begin
                        state_q <= ST_WAIT;
                        op_q    <= op;
                        off_q   <= MEM_in_alu_result[1:0];
                    end else if (mem_act) begin
                        state_q <= ST_REQ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (dmem_data_ok) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    mem_load_align u_load_align (
        .op_i     (op_q),
        .offset_i (off_q),
        .rdata_i  (dmem_rdata),
        .data_o   (load_data)
    );

    assign MEM_out_RF_wdata = (mem_act && is_load(op)) ? load_data : MEM_in_alu_result;
    assign MEM_out_RF_waddr = MEM_in_RF_waddr;
    assign MEM_out_RF_wen   = rst_n & MEM_in_valid & MEM_in_RF_wen & ~is_store(op) & ~misalign;
    assign MEM_out_PC       = MEM_in_PC;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: pass-through, loads, stores, bus delays and reset mid-transaction.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        MEM_in_valid;
    logic [3:0]  MEM_in_mem_op;
    logic [31:0] MEM_in_alu_result;
    logic [31:0] MEM_in_store_data;
    logic [4:0]  MEM_in_RF_waddr;
    logic        MEM_in_RF_wen;
    logic [31:0] MEM_in_PC;
    logic        dmem_req;
    logic        dmem_wr;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_addr_ok;
    logic        dmem_data_ok;
    logic [31:0] dmem_rdata;
    logic [31:0] MEM_out_RF_wdata;
    logic [4:0]  MEM_out_RF_waddr;
    logic        MEM_out_RF_wen;
    logic [31:0] MEM_out_PC;
    logic        MEM_stall;
`ifdef MEM_ALIGN_CHECK_EN
    logic        MEM_out_addr_exc;
    logic [31:0] MEM_out_badvaddr;
`endif

    typedef struct {
        logic [31:0] data;
        logic        wen;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    mem_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .MEM_in_valid      (MEM_in_valid),
        .MEM_in_mem_op     (MEM_in_mem_op),
        .MEM_in_alu_result (MEM_in_alu_result),
        .MEM_in_store_data (MEM_in_store_data),
        .MEM_in_RF_waddr   (MEM_in_RF_waddr),
        .MEM_in_RF_wen     (MEM_in_RF_wen),
        .MEM_in_PC         (MEM_in_PC),
        .dmem_req          (dmem_req),
        .dmem_wr           (dmem_wr),
        .dmem_addr         (dmem_addr),
        .dmem_wstrb        (dmem_wstrb),
        .dmem_wdata        (dmem_wdata),
        .dmem_addr_ok      (dmem_addr_ok),
        .dmem_data_ok      (dmem_data_ok),
        .dmem_rdata        (dmem_rdata),
        .MEM_out_RF_wdata  (MEM_out_RF_wdata),
        .MEM_out_RF_waddr  (MEM_out_RF_waddr),
        .MEM_out_RF_wen    (MEM_out_RF_wen),
        .MEM_out_PC        (MEM_out_PC),
`ifdef MEM_ALIGN_CHECK_EN
        .MEM_out_addr_exc  (MEM_out_addr_exc),
        .MEM_out_badvaddr  (MEM_out_badvaddr),
`endif
        .MEM_stall         (MEM_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] waddr, input logic wen);
        MEM_in_valid      = v;
        MEM_in_mem_op     = op;
        MEM_in_alu_result = addr;
        MEM_in_store_data = sdata;
        MEM_in_RF_waddr   = waddr;
        MEM_in_RF_wen     = wen;
        MEM_in_PC         = addr ^ 32'hBFC0_0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dmem_addr_ok = 1'b0; dmem_data_ok = 1'b0; dmem_rdata = 32'h0;
        drive(1'b1, 4'd5, 32'h0000_0100, 32'h0, 5'd3, 1'b1);
        #2;
        checks++;
        if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", dmem_req); end
        checks++;
        if (MEM_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", MEM_stall); end
        checks++;
        if (MEM_out_RF_wen !== 1'b0) begin failures++; $display("FAIL reset_wen: got %b want 0", MEM_out_RF_wen); end
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_passthru();
        drive(1'b1, 4'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        sb.push_back('{data: 32'h0000_1234, wen: 1'b1, chk_data: 1'b1});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (MEM_out_RF_wdata !== e.data) begin failures++; $display("FAIL pass_wdata: got %h want %h", MEM_out_RF_wdata, e.data); end
        checks++;
        if (MEM_out_RF_wen !== e.wen) begin failures++; $display("FAIL pass_wen: got %b want %b", MEM_out_RF_wen, e.wen); end
        checks++;
        if (MEM_out_RF_waddr !== 5'd5 || MEM_out_PC !== (32'h0000_1234 ^ 32'hBFC0_0000)) begin
            failures++; $display("FAIL pass_waddr_pc: got %0d/%h want 5/%h", MEM_out_RF_waddr, MEM_out_PC, 32'h0000_1234 ^ 32'hBFC0_0000);
        end
        checks++;
        if (dmem_req !== 1'b0 || MEM_stall !== 1'b0) begin failures++; $display("FAIL pass_req_stall: got %b/%b want 0/0", dmem_req, MEM_stall); end
        drive(1'b0, 4'd0, 32'h0000_5555, 32'h0, 5'd6, 1'b1);
        #1;
        checks++;
        if (MEM_out_RF_wen !== 1'b0) begin failures++; $display("FAIL bubble_wen: got %b want 0", MEM_out_RF_wen); end
        step();
        $display("test_passthru done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_lb();
        int stall_cycles = 0;
        drive(1'b1, 4'd1, 32'h0000_1003, 32'h0, 5'd7, 1'b1);
        dmem_addr_ok = 1'b1;
        sb.push_back('{data: 32'hFFFF_FF80, wen: 1'b1, chk_data: 1'b1});
        @(negedge clk);
        if (MEM_stall === 1'b1) stall_cycles++;
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_1000 || dmem_wr !== 1'b0) begin
            failures++; $display("FAIL lb_req: got req=%b addr=%h wr=%b want 1/00001000/0", dmem_req, dmem_addr, dmem_wr);
        end
        step();
        dmem_addr_ok = 1'b0; dmem_data_ok = 1'b1; dmem_rdata = 32'h80FF_FF12;
        @(negedge clk);
        if (MEM_stall === 1'b1) stall_cycles++;
        e = sb.pop_front();
        checks++;
        if (MEM_out_RF_wdata !== e.data || MEM_out_RF_wen !== e.wen) begin
            failures++; $display("FAIL lb_data: got %h/%b want %h/%b", MEM_out_RF_wdata, MEM_out_RF_wen, e.data, e.wen);
        end
        checks++;
        if (stall_cycles != 1) begin failures++; $display("FAIL lb_stall_cycles: got %0d want 1", stall_cycles); end
        step();
        dmem_data_ok = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        $display("test_lb done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_sh();
        drive(1'b1, 4'd7, 32'h0000_2002, 32'h1234_ABCD, 5'd9, 1'b1);
        sb.push_back('{data: 32'h0, wen: 1'b0, chk_data: 1'b0});
        for (int i = 0; i < 4; i++) begin
            dmem_addr_ok = (i == 3);
            @(negedge clk);
            checks++;
            if (dmem_req !== 1'b1 || dmem_wr !== 1'b1 || dmem_wstrb !== 4'b1100 ||
                dmem_wdata !== 32'hABCD_ABCD || dmem_addr !== 32'h0000_2000 || MEM_stall !== 1'b1) begin
                failures++;
                $display("FAIL sh_req%0d: got req=%b wr=%b strb=%b wdata=%h addr=%h stall=%b want 1/1/1100/abcdabcd/00002000/1",
                         i, dmem_req, dmem_wr, dmem_wstrb, dmem_wdata, dmem_addr, MEM_stall);
            end
            step();
        end
        dmem_addr_ok = 1'b0; dmem_data_ok = 1'b1;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (MEM_stall !== 1'b0 || MEM_out_RF_wen !== e.wen || dmem_req !== 1'b0) begin
            failures++; $display("FAIL sh_done: got stall=%b wen=%b req=%b want 0/%b/0", MEM_stall, MEM_out_RF_wen, dmem_req, e.wen);
        end
        step();
        dmem_data_ok = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        $display("test_sh done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_lhu();
        dmem_data_ok = 1'b1; dmem_rdata = 32'hDEAD_DEAD;
        step();
        dmem_data_ok = 1'b0;
        drive(1'b1, 4'd4, 32'h0000_0000, 32'h0, 5'd11, 1'b1);
        dmem_addr_ok = 1'b1;
        sb.push_back('{data: 32'h0000_8001, wen: 1'b1, chk_data: 1'b1});
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || MEM_stall !== 1'b1) begin
            failures++; $display("FAIL lhu_issue: got req=%b stall=%b want 1/1", dmem_req, MEM_stall);
        end
        step();
        dmem_addr_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (MEM_stall !== 1'b1 || dmem_req !== 1'b0) begin
                failures++; $display("FAIL lhu_wait%0d: got stall=%b req=%b want 1/0", i, MEM_stall, dmem_req);
            end
            step();
        end
        dmem_data_ok = 1'b1; dmem_rdata = 32'h0000_8001;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (MEM_out_RF_wdata !== e.data || MEM_stall !== 1'b0) begin
            failures++; $display("FAIL lhu_data: got %h stall=%b want %h stall=0", MEM_out_RF_wdata, MEM_stall, e.data);
        end
        step();
        dmem_data_ok = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        $display("test_lhu done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'd5, 32'h0000_3000, 32'h0, 5'd12, 1'b1);
        dmem_addr_ok = 1'b1;
        step();
        dmem_addr_ok = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || MEM_stall !== 1'b0 || MEM_out_RF_wen !== 1'b0) begin
            failures++; $display("FAIL rstmid_outs: got req=%b stall=%b wen=%b want 0/0/0", dmem_req, MEM_stall, MEM_out_RF_wen);
        end
        step();
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        rst_n = 1'b1;
        dmem_data_ok = 1'b1; dmem_rdata = 32'h1111_1111;
        step();
        dmem_data_ok = 1'b0;
        drive(1'b1, 4'd5, 32'h0000_4004, 32'h0, 5'd13, 1'b1);
        dmem_addr_ok = 1'b1;
        sb.push_back('{data: 32'hDEAD_BEEF, wen: 1'b1, chk_data: 1'b1});
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_4004 || dmem_wr !== 1'b0) begin
            failures++; $display("FAIL rstmid_fresh_req: got req=%b addr=%h wr=%b want 1/00004004/0", dmem_req, dmem_addr, dmem_wr);
        end
        step();
        dmem_addr_ok = 1'b0; dmem_data_ok = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (MEM_out_RF_wdata !== e.data || MEM_stall !== 1'b0) begin
            failures++; $display("FAIL rstmid_fresh_data: got %h stall=%b want %h stall=0", MEM_out_RF_wdata, MEM_stall, e.data);
        end
        step();
        dmem_data_ok = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 4'd3, 32'h0000_6002, 32'h0, 5'd14, 1'b1);
        dmem_addr_ok = 1'b1;
        sb.push_back('{data: 32'hFFFF_8765, wen: 1'b1, chk_data: 1'b1});
        step();
        dmem_addr_ok = 1'b0; dmem_data_ok = 1'b1; dmem_rdata = 32'h8765_4321;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (MEM_out_RF_wdata !== e.data || MEM_stall !== 1'b0) begin
            failures++; $display("FAIL b2b_lh: got %h stall=%b want %h stall=0", MEM_out_RF_wdata, MEM_stall, e.data);
        end
        step();
        dmem_data_ok = 1'b0;
        drive(1'b1, 4'd6, 32'h0000_5001, 32'h0000_0077, 5'd15, 1'b1);
        dmem_addr_ok = 1'b1;
        sb.push_back('{data: 32'h0, wen: 1'b0, chk_data: 1'b0});
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || dmem_wstrb !== 4'b0010 || dmem_wdata !== 32'h7777_7777 || dmem_addr !== 32'h0000_5000) begin
            failures++; $display("FAIL b2b_sb_req: got req=%b strb=%b wdata=%h addr=%h want 1/0010/77777777/00005000",
                                 dmem_req, dmem_wstrb, dmem_wdata, dmem_addr);
        end
        step();
        dmem_addr_ok = 1'b0; dmem_data_ok = 1'b1;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (MEM_out_RF_wen !== e.wen || MEM_stall !== 1'b0) begin
            failures++; $display("FAIL b2b_sb_done: got wen=%b stall=%b want %b/0", MEM_out_RF_wen, MEM_stall, e.wen);
        end
        step();
        dmem_data_ok = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        $display("test_back_to_back done checks=%0d failures=%0d", checks, failures);
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_align();
        drive(1'b1, 4'd5, 32'h0000_1002, 32'h0, 5'd16, 1'b1);
        dmem_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || MEM_stall !== 1'b0 || MEM_out_addr_exc !== 1'b1 ||
            MEM_out_badvaddr !== 32'h0000_1002 || MEM_out_RF_wen !== 1'b0) begin
            failures++; $display("FAIL align_lw: got req=%b stall=%b exc=%b bad=%h wen=%b want 0/0/1/00001002/0",
                                 dmem_req, MEM_stall, MEM_out_addr_exc, MEM_out_badvaddr, MEM_out_RF_wen);
        end
        step();
        dmem_addr_ok = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        $display("test_align done checks=%0d failures=%0d", checks, failures);
    endtask
`endif

    initial begin
        test_reset();
        test_passthru();
        test_lb();
        test_sh();
        test_lhu();
        test_reset_mid();
        test_back_to_back();
`ifdef MEM_ALIGN_CHECK_EN
        test_align();
`endif
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_left: got %0d entries want 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
